mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Memory-side responder for the CPU core's bus (memread/memwrite/memaddr/memwdata → memrdata). It serves core requests from a word-organised on-chip RAM and a small MMIO window containing a GPIO output register, a free-running cycle counter and a sticky error/status register. Reads are registered, so the core's multicycle controller samples read data one cycle after asserting memread.

Parameters:
WIDTH, 32, data word width; the only supported value is 32.
ADDR_WIDTH, 32, byte-address width.
DEPTH_LOG2, 10, log2 of the number of RAM words (default 1024 words = 4 KiB).
MMIO_BASE, 32'hFFFF_0000, byte address of the MMIO window; the window is 16 bytes.
INIT_FILE, "", hex image loaded into RAM at elaboration with $readmemh; an empty string means no load.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
memread_i  input  1  read request, sampled at the rising edge
memwrite_i  input  1  write request, sampled at the rising edge
memaddr_i  input  ADDR_WIDTH  byte address
memwdata_i  input  WIDTH  write data
memrdata_o  output  WIDTH  registered read data
rdvalid_o  output  1  one-cycle pulse: memrdata_o was updated by a read this cycle
gpio_o  output  WIDTH  GPIO output register
err_o  output  1  sticky access-error flag

Behaviour:
- Reset (rst=0, asynchronous): memrdata_o=0, rdvalid_o=0, gpio_o=0, cycle counter=0, err_o=0. RAM contents are not cleared. Asserting reset mid-access discards that access; no write occurs.
- Address decode, evaluated at each edge:
  - MMIO: memaddr_i[ADDR_WIDTH-1:4] == MMIO_BASE[ADDR_WIDTH-1:4].
  - RAM: memaddr_i < 4<<DEPTH_LOG2. Word index = memaddr_i[DEPTH_LOG2+1:2].
  - Anything else is unmapped.
- Misaligned access (memaddr_i[1:0] != 0, any region) is an error.
- Read (memread_i=1 at edge N):
  - memrdata_o takes the addressed word at edge N.
  - rdvalid_o is high for the cycle following edge N.
  - Latency is 1 cycle.
  - memrdata_o holds its value until the next read.
- Write (memwrite_i=1 at edge N): the addressed location is updated at edge N.
- Read and write in the same cycle: the write is performed, and memrdata_o returns the newly written data (write-first).
- Error access (misaligned or unmapped):
  - A write is ignored.
  - A read returns 0 with rdvalid_o still pulsed.
  - err_o is set at the same edge.
  - Access to an undefined MMIO offset (0xC) is also an error.
- MMIO map (byte offset from MMIO_BASE):
  - 0x0 GPIO: read/write; a write loads gpio_o at the edge.
  - 0x4 CYCLE: read-only. The 32-bit counter increments every cycle out of reset and wraps from 0xFFFF_FFFF to 0. A read returns the value before that edge's increment. A write is ignored and is not an error.
  - 0x8 STATUS: bit0 = err_o, other bits read 0. Writing bit0=1 clears err_o.
    - If a clearing write and a new error occur at the same edge, the set wins.
    - A clearing write to STATUS is never itself an error.
- No request (both strobes 0): no state change except the counter; rdvalid_o=0.
- An internal RAM array with a synchronous read port must infer block RAM; the write-first muxing is done outside the array.

Test Plan:
1. Reset, release, then idle 5 cycles → memrdata_o=0, gpio_o=0, err_o=0; a read of MMIO_BASE+4 issued on the 6th cycle after release returns 5.
2. Write 0x1234_5678 to 0x0000_0010, then read 0x10 on the next cycle → memrdata_o=0x1234_5678 one cycle after the read; rdvalid_o high for exactly that one cycle.
3. memread and memwrite both high, addr 0x20, wdata 0xA5A5_A5A5 → memrdata_o=0xA5A5_A5A5 after the edge; a later read of 0x20 returns the same value.
4. Write 0xFF to 0x0000_0013 (misaligned), then read 0x0000_1000 (unmapped with DEPTH_LOG2=10) → the write is dropped (word 0x10 unchanged), err_o=1, the read returns 0; reading MMIO_BASE+8 returns 0x1; writing 1 to MMIO_BASE+8 clears err_o.
5. Write 0x0000_00F0 to MMIO_BASE+0 → gpio_o=0x0000_00F0 at that edge; a read of MMIO_BASE+0 returns 0xF0; writing MMIO_BASE+4 leaves the counter sequence unbroken and err_o=0.
6. Assert rst low mid-cycle while memwrite_i is high to 0x40 with data 0x1 (previous content 0x7) → outputs go to reset values immediately; after release, a read of 0x40 returns 0x7. Also force the counter near 0xFFFF_FFFF (hierarchical deposit) and observe the wrap to 0.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the core bus: word RAM with a registered read port plus
// a 16-byte MMIO window (GPIO, free-running cycle counter, sticky error status).
module mem_responder #(
  parameter int                    WIDTH      = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter                        INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memread_i,
  input  logic                  memwrite_i,
  input  logic [ADDR_WIDTH-1:0] memaddr_i,
  input  logic [WIDTH-1:0]      memwdata_i,
  output logic [WIDTH-1:0]      memrdata_o,
  output logic                  rdvalid_o,
  output logic [WIDTH-1:0]      gpio_o,
  output logic                  err_o
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [ADDR_WIDTH:0] RAM_BYTES = (ADDR_WIDTH + 1)'(4) << DEPTH_LOG2;

  typedef enum logic [1:0] {
    OFF_GPIO   = 2'd0,
    OFF_CYCLE  = 2'd1,
    OFF_STATUS = 2'd2,
    OFF_RSVD   = 2'd3
  } mmio_off_e;

  logic [WIDTH-1:0]      ram [0:DEPTH-1];
  logic [WIDTH-1:0]      ramRd_q;

  logic [WIDTH-1:0]      gpio_q,      gpio_d;
  logic [WIDTH-1:0]      cycle_q,     cycle_d;
  logic [WIDTH-1:0]      rdData_q,    rdData_d;
  logic                  rdFromRam_q, rdFromRam_d;
  logic                  rdValid_q,   rdValid_d;
  logic                  err_q,       err_d;

  logic                  hitMmio;
  logic                  hitRam;
  logic                  misaligned;
  logic                  badAddr;
  logic                  anyReq;
  logic                  wrOk;
  logic                  rdOk;
  logic                  statusClr;
  logic                  ramWe;
  logic                  ramRe;
  mmio_off_e             mmioOff;
  logic [DEPTH_LOG2-1:0] ramIdx;

  assign hitMmio    = (memaddr_i[ADDR_WIDTH-1:4] == MMIO_BASE[ADDR_WIDTH-1:4]);
  assign hitRam     = ({1'b0, memaddr_i} < RAM_BYTES);
  assign misaligned = |memaddr_i[1:0];
  assign mmioOff    = mmio_off_e'(memaddr_i[3:2]);
  assign ramIdx     = memaddr_i[DEPTH_LOG2+1:2];

  assign badAddr    = misaligned | (~hitMmio & ~hitRam) | (hitMmio & (mmioOff == OFF_RSVD));
  assign anyReq     = memread_i | memwrite_i;
  assign wrOk       = memwrite_i & ~badAddr;
  assign rdOk       = memread_i & ~badAddr;
  assign statusClr  = wrOk & hitMmio & (mmioOff == OFF_STATUS) & memwdata_i[0];

  // The array has no reset, so gate its enables with rst to drop accesses held in reset.
  assign ramWe = wrOk & hitRam & rst;
  assign ramRe = rdOk & hitRam & ~memwrite_i & rst;

  always_ff @(posedge clk) begin
    if (ramWe) begin
      ram[ramIdx] <= memwdata_i;
    end
    if (ramRe) begin
      ramRd_q <= ram[ramIdx];
    end
  end

  always_comb begin
    gpio_d      = gpio_q;
    cycle_d     = cycle_q + 1'b1;
    err_d       = err_q;
    rdData_d    = rdData_q;
    rdFromRam_d = rdFromRam_q;
    rdValid_d   = memread_i;

    if (wrOk && hitMmio && (mmioOff == OFF_GPIO)) begin
      gpio_d = memwdata_i;
    end

    // A new error at the same edge as a clearing write must win.
    if (statusClr) begin
      err_d = 1'b0;
    end
    if (anyReq && badAddr) begin
      err_d = 1'b1;
    end

    if (memread_i) begin
      rdFromRam_d = 1'b0;
      if (badAddr) begin
        rdData_d = '0;
      end else if (hitRam) begin
        if (memwrite_i) begin
          rdData_d = memwdata_i;
        end else begin
          rdFromRam_d = 1'b1;
        end
      end else begin
        case (mmioOff)
          OFF_GPIO:   rdData_d = gpio_d;
          OFF_CYCLE:  rdData_d = cycle_q;
          OFF_STATUS: rdData_d = {{(WIDTH-1){1'b0}}, err_d};
          default:    rdData_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_q      <= '0;
      cycle_q     <= '0;
      err_q       <= 1'b0;
      rdData_q    <= '0;
      rdFromRam_q <= 1'b0;
      rdValid_q   <= 1'b0;
    end else begin
      gpio_q      <= gpio_d;
      cycle_q     <= cycle_d;
      err_q       <= err_d;
      rdData_q    <= rdData_d;
      rdFromRam_q <= rdFromRam_d;
      rdValid_q   <= rdValid_d;
    end
  end

  assign memrdata_o = rdFromRam_q ? ramRd_q : rdData_q;
  assign rdvalid_o  = rdValid_q;
  assign gpio_o     = gpio_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM, write-first, error handling, MMIO and reset.
module tb_mem_responder;

  localparam logic [31:0] MMIO = 32'hFFFF_0000;

  logic        clk;
  logic        rst;
  logic        memread_i;
  logic        memwrite_i;
  logic [31:0] memaddr_i;
  logic [31:0] memwdata_i;
  logic [31:0] memrdata_o;
  logic        rdvalid_o;
  logic [31:0] gpio_o;
  logic        err_o;

  int          vectors;
  int          miscompares;
  int          cyc;
  logic [31:0] cycExp;

  mem_responder #(
    .WIDTH      (32),
    .ADDR_WIDTH (32),
    .DEPTH_LOG2 (10),
    .MMIO_BASE  (32'hFFFF_0000),
    .INIT_FILE  ("")
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .memread_i  (memread_i),
    .memwrite_i (memwrite_i),
    .memaddr_i  (memaddr_i),
    .memwdata_i (memwdata_i),
    .memrdata_o (memrdata_o),
    .rdvalid_o  (rdvalid_o),
    .gpio_o     (gpio_o),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request at a negedge, let it hit the next posedge, return at the following negedge.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata);
    memread_i  = rd;
    memwrite_i = wr;
    memaddr_i  = addr;
    memwdata_i = wdata;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    memread_i  = 1'b0;
    memwrite_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rst         = 1'b0;
    memread_i   = 1'b0;
    memwrite_i  = 1'b0;
    memaddr_i   = '0;
    memwdata_i  = '0;

    // 1: reset values, then counter read after 5 idle cycles
    repeat (2) @(negedge clk);
    checkOutput("rst_rdata", memrdata_o, 32'h0);
    checkOutput("rst_rdvalid", {31'b0, rdvalid_o}, 32'h0);
    checkOutput("rst_gpio", gpio_o, 32'h0);
    checkOutput("rst_err", {31'b0, err_o}, 32'h0);
    rst = 1'b1;
    cyc = 0;
    idle(5);
    checkOutput("idle_rdata", memrdata_o, 32'h0);
    checkOutput("idle_gpio", gpio_o, 32'h0);
    checkOutput("idle_err", {31'b0, err_o}, 32'h0);
    applyStimulus(1'b1, 1'b0, MMIO + 32'h4, 32'h0);
    checkOutput("cycle_after5", memrdata_o, 32'd5);
    checkOutput("cycle_rdvalid", {31'b0, rdvalid_o}, 32'h1);

    // 2: write then read RAM
    applyStimulus(1'b0, 1'b1, 32'h10, 32'h1234_5678);
    checkOutput("wr_rdvalid", {31'b0, rdvalid_o}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
    checkOutput("ram_rd10", memrdata_o, 32'h1234_5678);
    checkOutput("ram_rdvalid", {31'b0, rdvalid_o}, 32'h1);
    idle(1);
    checkOutput("ram_rdvalid_drop", {31'b0, rdvalid_o}, 32'h0);
    checkOutput("ram_rd_hold", memrdata_o, 32'h1234_5678);

    // 3: simultaneous read/write is write-first
    applyStimulus(1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5);
    checkOutput("wf_rdata", memrdata_o, 32'hA5A5_A5A5);
    checkOutput("wf_rdvalid", {31'b0, rdvalid_o}, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
    checkOutput("wf_reread", memrdata_o, 32'hA5A5_A5A5);

    // 4: misaligned write, unmapped read, status read and clear
    applyStimulus(1'b0, 1'b1, 32'h13, 32'hFF);
    checkOutput("mis_err", {31'b0, err_o}, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h1000, 32'h0);
    checkOutput("unmap_rdata", memrdata_o, 32'h0);
    checkOutput("unmap_rdvalid", {31'b0, rdvalid_o}, 32'h1);
    checkOutput("unmap_err", {31'b0, err_o}, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
    checkOutput("mis_dropped", memrdata_o, 32'h1234_5678);
    applyStimulus(1'b1, 1'b0, MMIO + 32'h8, 32'h0);
    checkOutput("status_rd", memrdata_o, 32'h1);
    applyStimulus(1'b0, 1'b1, MMIO + 32'h8, 32'h1);
    checkOutput("status_clr", {31'b0, err_o}, 32'h0);
    applyStimulus(1'b1, 1'b0, MMIO + 32'hC, 32'h0);
    checkOutput("rsvd_rdata", memrdata_o, 32'h0);
    checkOutput("rsvd_err", {31'b0, err_o}, 32'h1);
    applyStimulus(1'b0, 1'b1, MMIO + 32'h8, 32'h1);
    checkOutput("status_clr2", {31'b0, err_o}, 32'h0);

    // 5: GPIO and read-only counter
    applyStimulus(1'b0, 1'b1, MMIO, 32'h0000_00F0);
    checkOutput("gpio_wr", gpio_o, 32'h0000_00F0);
    applyStimulus(1'b1, 1'b0, MMIO, 32'h0);
    checkOutput("gpio_rd", memrdata_o, 32'h0000_00F0);
    cycExp = 32'(cyc);
    applyStimulus(1'b1, 1'b0, MMIO + 32'h4, 32'h0);
    checkOutput("cycle_pre", memrdata_o, cycExp);
    applyStimulus(1'b0, 1'b1, MMIO + 32'h4, 32'hDEAD_BEEF);
    checkOutput("cycle_wr_noerr", {31'b0, err_o}, 32'h0);
    cycExp = 32'(cyc);
    applyStimulus(1'b1, 1'b0, MMIO + 32'h4, 32'h0);
    checkOutput("cycle_post", memrdata_o, cycExp);

    // 6: reset asserted mid-write discards the write
    applyStimulus(1'b0, 1'b1, 32'h40, 32'h7);
    applyStimulus(1'b0, 1'b1, 32'h42, 32'h9);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
    checkOutput("pre_rst_rdata", memrdata_o, 32'h7);
    checkOutput("pre_rst_err", {31'b0, err_o}, 32'h1);
    memwrite_i = 1'b1;
    memaddr_i  = 32'h40;
    memwdata_i = 32'h1;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rdata", memrdata_o, 32'h0);
    checkOutput("async_rdvalid", {31'b0, rdvalid_o}, 32'h0);
    checkOutput("async_gpio", gpio_o, 32'h0);
    checkOutput("async_err", {31'b0, err_o}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    memwrite_i = 1'b0;
    rst = 1'b1;
    cyc = 0;
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
    checkOutput("rst_no_write", memrdata_o, 32'h7);
    applyStimulus(1'b1, 1'b0, MMIO + 32'h4, 32'h0);
    checkOutput("cycle_after_rst", memrdata_o, 32'd1);

    // Counter wrap via deposit
    dut.cycle_q = 32'hFFFF_FFFE;
    applyStimulus(1'b1, 1'b0, MMIO + 32'h4, 32'h0);
    checkOutput("wrap_fffe", memrdata_o, 32'hFFFF_FFFE);
    applyStimulus(1'b1, 1'b0, MMIO + 32'h4, 32'h0);
    checkOutput("wrap_ffff", memrdata_o, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0, MMIO + 32'h4, 32'h0);
    checkOutput("wrap_zero", memrdata_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
